seq_multiplier_param: RTL

//  Parametrised iterative shift-add multiplier with start/busy/done handshake.

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_multiplier_param_if.sv | 12 +
 rtl/seq_mult_sign_fix.sv | 8 +
 rtl/seq_multiplier_param.sv | 76 +++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction
  // Magnitude of the low w bits of value; -2^(w-1) maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [63:0] abs_val(input logic [63:0] value, input logic signed_en, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (signed_en && value[w-1]) ? ((~value + 64'd1) & mask) : (value & mask);
  endfunction
endpackage

// File: rtl/seq_multiplier_param_if.sv
// seq_multiplier_param_if: start/busy/done handshake and operand/product bus of the multiplier.
interface seq_multiplier_param_if #(parameter int WIDTH = 8);
  logic               start;
  logic               signed_en;
  logic [WIDTH-1:0]   ina;
  logic [WIDTH-1:0]   inb;
  logic [2*WIDTH-1:0] out;
  logic               busy;
  logic               done;
  modport master (output start, signed_en, ina, inb, input out, busy, done);
  modport slave  (input start, signed_en, ina, inb, output out, busy, done);
endinterface

// File: rtl/seq_mult_sign_fix.sv
// seq_mult_sign_fix: conditional two's-complement negate of the final product.
module seq_mult_sign_fix #(parameter int W2 = 16) (
  input  logic [W2-1:0] val_i,
  input  logic          neg_i,
  output logic [W2-1:0] val_o
);
  assign val_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: iterative shift-add WIDTH x WIDTH multiplier, signed or unsigned per operation.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  seq_multiplier_param_if.slave bus
);
  localparam int CNT_W = clog2w(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [W2-1:0]    pp_q, pp_d, step, res, fixed, out_q, out_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   sum;
  logic             neg_q, neg_d, done_q, done_d, fin;
  assign sum     = {1'b0, pp_q[W2-1:WIDTH]} + {1'b0, mcand_q};
  assign step    = pp_q[0] ? {sum, pp_q[WIDTH-1:1]} : (pp_q >> 1);
  assign cnt_dec = cnt_q - CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
  // The low cnt_dec bits of step are the multiplier bits still to be consumed.
  assign fin = (cnt_dec == '0) || ((step & ((W2'(1) << cnt_dec) - W2'(1))) == '0);
  assign res = step >> cnt_dec;
`else
  assign fin = (cnt_dec == '0);
  assign res = step;
`endif
  seq_mult_sign_fix #(.W2(W2)) u_sign_fix (.val_i(res), .neg_i(neg_q), .val_o(fixed));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pp_d    = pp_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      cnt_d   = CNT_W'(WIDTH);
      mcand_d = WIDTH'(abs_val(64'(bus.ina), bus.signed_en, WIDTH));
      pp_d    = {{WIDTH{1'b0}}, WIDTH'(abs_val(64'(bus.inb), bus.signed_en, WIDTH))};
      neg_d   = bus.signed_en & (bus.ina[WIDTH-1] ^ bus.inb[WIDTH-1]);
    end else if (state_q == RUN) begin
      pp_d    = step;
      cnt_d   = cnt_dec;
      state_d = fin ? IDLE : RUN;
      out_d   = fin ? fixed : out_q;
      done_d  = fin;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pp_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pp_q    <= pp_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
  assign bus.out  = out_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
endmodule
